oam_scan: RTL and testbench
===========================

Name: oam_scan

Overview:
- PPU mode-2 object search: the first consumer of the OAM contents that the OAM DMA unit fills (FE00–FE9F).
- At the start of each visible line, reads the Y and X bytes of all 40 OAM entries and selects the first 10 objects that intersect the current line.
- Stores the selection in a small buffer, in OAM order, for the pixel fetcher.
- While OAM DMA owns the bus, OAM reads are treated as 0xFF, as on hardware.

Parameters:
- NUM_OAM, 40: OAM entries scanned per line.
- MAX_OBJ, 10: selection buffer depth.

Ports:
- clk  in  1  PPU dot clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin scan for current line.
- ly  in  8  current line, sampled on start.
- obj_size  in  1  LCDC.2 (0 = 8-row objects, 1 = 16-row objects), sampled on start.
- dma_active  in  1  OAM DMA owns the bus (DMA dma_occupy_bus).
- oam_rd  out  1  OAM read strobe.
- oam_a  out  8  OAM byte index, 0x00–0x9F.
- oam_din  in  8  OAM read data, valid the cycle after oam_rd.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; buffer final.
- obj_count  out  4  entries stored, 0..MAX_OBJ.
- overflow  out  1  more than MAX_OBJ matches this line.
- obj_rd_idx  in  4  buffer read index.
- obj_x  out  8  X byte of selected entry.
- obj_num  out  6  OAM entry number (0..39).
- obj_row  out  4  row within object (0..15).

Behaviour:
Reset (rst_n low, asynchronous):
- State IDLE.
- oam_rd, busy, done, overflow = 0; obj_count = 0; oam_a = 0x00.
- All buffer entries cleared.

States: IDLE, SCAN, DRAIN, DONE.

IDLE:
- oam_rd = 0.
- On start: latch ly and obj_size, clear obj_count and overflow, k = 0, go to SCAN.

SCAN (k = 0..79, one cycle each):
- oam_rd = 1.
- oam_a = 4*(k>>1) + (k&1), so the sequence is 0x00, 0x01, 0x04, 0x05, … 0x9C, 0x9D.
- Bytes 2–3 of each entry are never read.
- After k = 79, go to DRAIN.

Data pipeline (one cycle behind the address):
- Effective data d = dma_active ? 0xFF : oam_din, evaluated in the cycle the data arrives.
- Y byte arrives: compute diff = {1'b0, ly_l} + 16 − {1'b0, d} in 9 bits. Set match = (diff < height), where height = 8 or 16. Hold the match flag and diff[3:0].
- X byte arrives: if match and obj_count < MAX_OBJ, write {d, n, diff[3:0]} to buffer[obj_count] and increment obj_count.
- If match and obj_count == MAX_OBJ: set overflow; buffer unchanged.

DRAIN:
- Captures the final X byte.
- Next state DONE.

DONE:
- done = 1 for exactly one cycle, then IDLE.
- Timing: start sampled at edge E0 → oam_rd high for cycles 1..80 → DRAIN at cycle 81 → done at cycle 82.
- busy = 1 from cycle 1 through cycle 82 inclusive.

Read port (combinational):
- obj_x, obj_num, obj_row = buffer[obj_rd_idx] when obj_rd_idx < obj_count.
- Otherwise all three are 0.
- Buffer contents persist until the next start.

Boundaries:
- Objects with X = 0 or X ≥ 168 still occupy a slot.
- Y = 0xFF (including DMA-masked reads) never matches, since ly ≤ 153.
- Y = 0 matches nothing in 8-row or 16-row mode. Y = 16 matches line 0.
- 16-row mode with Y = ly + 1 gives row 15.
- start during SCAN/DRAIN/DONE: restart from k = 0 with newly latched ly/obj_size; count and overflow cleared; done not pulsed for the aborted scan.
- dma_active toggling mid-scan affects only the bytes that arrive while it is high.
- ly and obj_size changes after start are ignored until the next start.

Decomposition:
- Shared package gb_ppu_pkg holds:
  - OAM_BYTES (160)
  - OAM_ENTRY_STRIDE (4)
  - NUM_OAM, MAX_OBJ
  - OBJ_H8 / OBJ_H16 (8, 16)
  - the Y line offset 16
  - the state encoding constants
- Sub-module obj_buffer: MAX_OBJ × 18-bit register file with one write port, a synchronous async-reset clear, and a combinational read mux gated by count.

Test Plan:
- ly = 0x20, obj_size = 0, entry 3 = {Y 0x2A, X 0x50}, all others Y = 0x00 → at cycle 82: done, obj_count = 1, idx 0 gives x = 0x50, num = 3, row = 6.
- All 40 entries Y = 0x30, ly = 0x20 → obj_count = 10, overflow = 1, nums 0..9 in order; idx 10 reads all zeros.
- obj_size = 1, ly = 0x10, entry 7 Y = 0x11 → row = 15. Same setup with obj_size = 0 → obj_count = 0.
- As test 2, with dma_active held high over cycles 1..40 → entries 0..19 masked; nums 20..29 selected.
- start pulse again at cycle 30 with ly = 0x40 → oam_a restarts at 0x00; done arrives 82 cycles after the second start; results reflect ly = 0x40 only.
- rst_n low at cycle 50 → busy, oam_rd, and obj_count are 0 immediately. After release, no done pulse until a new start.

Source files
------------

// File: rtl/gb_ppu_pkg.sv
// Shared PPU constants and types: OAM geometry, object heights and the
// mode-2 scan state encoding.
package gb_ppu_pkg;

  localparam int OAM_BYTES        = 160;
  localparam int OAM_ENTRY_STRIDE = 4;
  localparam int NUM_OAM          = 40;
  localparam int MAX_OBJ          = 10;
  localparam int OBJ_H8           = 8;
  localparam int OBJ_H16          = 16;
  localparam int Y_OFFSET         = 16;
  localparam int SCAN_STEPS       = NUM_OAM * 2;

  localparam logic [3:0] MAX_OBJ_W = 4'(MAX_OBJ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [5:0] num;
    logic [3:0] row;
  } obj_entry_t;

  // Step k reads the Y byte (even k) or X byte (odd k) of entry k/2.
  function automatic logic [7:0] oam_addr(input logic [6:0] k);
    return {k[6:1], 1'b0, k[0]};
  endfunction

endpackage

// File: rtl/obj_buffer.sv
// Selected-object register file: one write port, cleared on reset, read
// mux returns zero for slots at or beyond the current fill count.
module obj_buffer
  import gb_ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  obj_entry_t wr_data,
  input  logic [3:0] count,
  input  logic [3:0] rd_idx,
  output obj_entry_t rd_data
);

  obj_entry_t mem [MAX_OBJ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OBJ; i++) mem[i] <= '0;
    end else if (wr_en && (wr_idx < MAX_OBJ_W)) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_idx < count) rd_data = mem[rd_idx];
  end

endmodule

// File: rtl/oam_scan.sv
// PPU mode-2 object search: reads Y/X of every OAM entry once per line and
// keeps the first MAX_OBJ objects that intersect the latched line.
module oam_scan
  import gb_ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] ly,
  input  logic       obj_size,
  input  logic       dma_active,
  output logic       oam_rd,
  output logic [7:0] oam_a,
  input  logic [7:0] oam_din,
  output logic       busy,
  output logic       done,
  output logic [3:0] obj_count,
  output logic       overflow,
  input  logic [3:0] obj_rd_idx,
  output logic [7:0] obj_x,
  output logic [5:0] obj_num,
  output logic [3:0] obj_row,
  output logic [1:0] state_dbg
);

  scan_state_e state;
  logic [6:0]  k;
  logic [7:0]  ly_l;
  logic        size_l;
  logic        pipe_valid;
  logic        pipe_is_x;
  logic [5:0]  pipe_n;
  logic        y_match;
  logic [3:0]  y_row;

  logic [7:0]  d;
  logic [8:0]  diff;
  logic [8:0]  height;
  logic        y_hit;
  logic        wr_en;
  obj_entry_t  wr_data;
  obj_entry_t  rd_data;

  // Data returns one cycle after the address; a DMA-owned bus reads as 0xFF.
  always_comb begin
    d       = dma_active ? 8'hFF : oam_din;
    diff    = {1'b0, ly_l} + 9'(Y_OFFSET) - {1'b0, d};
    height  = size_l ? 9'(OBJ_H16) : 9'(OBJ_H8);
    y_hit   = diff < height;
    wr_en   = !start && pipe_valid && pipe_is_x && y_match && (obj_count < MAX_OBJ_W);
    wr_data = '{x: d, num: pipe_n, row: y_row};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      k          <= '0;
      ly_l       <= '0;
      size_l     <= 1'b0;
      pipe_valid <= 1'b0;
      pipe_is_x  <= 1'b0;
      pipe_n     <= '0;
      y_match    <= 1'b0;
      y_row      <= '0;
      obj_count  <= '0;
      overflow   <= 1'b0;
      oam_rd     <= 1'b0;
      oam_a      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Restart from any state; in-flight data of an aborted scan is dropped.
        state      <= ST_SCAN;
        k          <= '0;
        ly_l       <= ly;
        size_l     <= obj_size;
        pipe_valid <= 1'b0;
        y_match    <= 1'b0;
        obj_count  <= '0;
        overflow   <= 1'b0;
        oam_rd     <= 1'b1;
        oam_a      <= 8'h00;
        busy       <= 1'b1;
      end else begin
        pipe_valid <= oam_rd;
        pipe_is_x  <= oam_a[0];
        pipe_n     <= oam_a[7:2];

        if (pipe_valid) begin
          if (!pipe_is_x) begin
            y_match <= y_hit;
            y_row   <= diff[3:0];
          end else if (y_match) begin
            if (obj_count < MAX_OBJ_W) obj_count <= obj_count + 4'd1;
            else                       overflow  <= 1'b1;
          end
        end

        case (state)
          ST_IDLE: begin
            oam_rd <= 1'b0;
          end
          ST_SCAN: begin
            if (k == 7'(SCAN_STEPS - 1)) begin
              state  <= ST_DRAIN;
              oam_rd <= 1'b0;
              oam_a  <= 8'h00;
            end else begin
              k     <= k + 7'd1;
              oam_a <= oam_addr(k + 7'd1);
            end
          end
          ST_DRAIN: begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  obj_buffer u_obj_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (obj_count),
    .wr_data (wr_data),
    .count   (obj_count),
    .rd_idx  (obj_rd_idx),
    .rd_data (rd_data)
  );

  assign obj_x     = rd_data.x;
  assign obj_num   = rd_data.num;
  assign obj_row   = rd_data.row;
  assign state_dbg = state;

endmodule

// File: tb/tb_oam_scan.sv
// Directed bench for oam_scan: an OAM byte model answers reads one cycle
// late, and each scan is checked for timing, address order and selection.
module tb_oam_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] ly;
  logic       obj_size;
  logic       dma_active;
  logic       oam_rd;
  logic [7:0] oam_a;
  logic [7:0] oam_din;
  logic       busy;
  logic       done;
  logic [3:0] obj_count;
  logic       overflow;
  logic [3:0] obj_rd_idx;
  logic [7:0] obj_x;
  logic [5:0] obj_num;
  logic [3:0] obj_row;
  logic [1:0] state_dbg;

  logic [7:0]  mem [160];
  logic [17:0] exp_q [$];

  int tests  = 0;
  int failed = 0;

  int done_cyc, done_cnt, busy_cnt, rd_cnt, addr_err;

  always #5 clk = ~clk;

  oam_scan dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ly         (ly),
    .obj_size   (obj_size),
    .dma_active (dma_active),
    .oam_rd     (oam_rd),
    .oam_a      (oam_a),
    .oam_din    (oam_din),
    .busy       (busy),
    .done       (done),
    .obj_count  (obj_count),
    .overflow   (overflow),
    .obj_rd_idx (obj_rd_idx),
    .obj_x      (obj_x),
    .obj_num    (obj_num),
    .obj_row    (obj_row),
    .state_dbg  (state_dbg)
  );

  // OAM model: address sampled at the edge, data presented for the next cycle.
  initial begin
    logic       rd_s;
    logic [7:0] a_s;
    oam_din = 8'h00;
    forever begin
      @(posedge clk);
      rd_s = oam_rd;
      a_s  = oam_a;
      #1;
      if (rd_s) oam_din = (a_s < 8'd160) ? mem[a_s] : 8'h00;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_addr(input int kk);
    return 8'((kk / 2) * 4 + (kk % 2));
  endfunction

  task automatic set_all(input logic [7:0] y);
    for (int i = 0; i < 40; i++) begin
      mem[4*i]   = y;
      mem[4*i+1] = 8'(8'h10 + i);
      mem[4*i+2] = 8'hEE;
      mem[4*i+3] = 8'hEE;
    end
  endtask

  task automatic run_scan(input logic [7:0] l, input logic sz, input int dma_hi,
                          input int restart_at, input logic [7:0] ly2);
    int s;
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; rd_cnt = 0; addr_err = 0;
    @(negedge clk);
    start = 1'b1; ly = l; obj_size = sz; dma_active = 1'b0;
    for (int c = 1; c <= 130; c++) begin
      @(negedge clk);
      start      = 1'b0;
      dma_active = (c <= dma_hi);
      s = (restart_at > 0 && c > restart_at) ? restart_at : 0;
      if (c == s + 1) begin
        ly = ~ly; obj_size = ~obj_size;
      end
      if (c == restart_at) begin
        start = 1'b1; ly = ly2; obj_size = sz;
      end
      if (oam_rd) begin
        rd_cnt++;
        if (oam_a !== exp_addr(c - s - 1)) addr_err++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
    end
    dma_active = 1'b0;
  endtask

  task automatic check_entry(input string tag, input logic [3:0] idx, input logic [17:0] exp);
    obj_rd_idx = idx;
    #1;
    check(tag, {14'd0, obj_x, obj_num, obj_row}, {14'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ly = 8'h00; obj_size = 1'b0;
    dma_active = 1'b0; obj_rd_idx = 4'd0;
    set_all(8'h00);
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy",     busy,      0);
    check("rst_done",     done,      0);
    check("rst_oam_rd",   oam_rd,    0);
    check("rst_oam_a",    oam_a,     0);
    check("rst_count",    obj_count, 0);
    check("rst_overflow", overflow,  0);
    check("rst_entry0",   {obj_x, obj_num, obj_row}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single hit, entry 3, row 6.
    set_all(8'h00);
    mem[12] = 8'h2A; mem[13] = 8'h50;
    run_scan(8'h20, 1'b0, 0, 0, 8'h00);
    check("t1_done_cyc",  done_cyc, 82);
    check("t1_done_cnt",  done_cnt, 1);
    check("t1_busy_cnt",  busy_cnt, 82);
    check("t1_rd_cnt",    rd_cnt,   80);
    check("t1_addr_seq",  addr_err, 0);
    check("t1_count",     obj_count, 1);
    check("t1_overflow",  overflow,  0);
    check_entry("t1_entry0", 4'd0, {8'h50, 6'd3, 4'd6});
    check_entry("t1_entry1", 4'd1, 18'd0);

    // Every entry hits: first ten kept in OAM order, X=0 and X=0xA8 kept.
    set_all(8'h30);
    mem[1] = 8'h00; mem[5] = 8'hA8;
    run_scan(8'h20, 1'b0, 0, 0, 8'h00);
    check("t2_done_cyc",  done_cyc, 82);
    check("t2_count",     obj_count, 10);
    check("t2_overflow",  overflow,  1);
    for (int i = 0; i < 10; i++)
      exp_q.push_back({(i == 0) ? 8'h00 : (i == 1) ? 8'hA8 : 8'(8'h10 + i), 6'(i), 4'd0});
    for (int i = 0; i < 10; i++) check_entry($sformatf("t2_entry%0d", i), 4'(i), exp_q.pop_front());
    check_entry("t2_entry10", 4'd10, 18'd0);

    // 16-row object with Y = ly + 1 gives row 15; 8-row mode misses it.
    set_all(8'h00);
    mem[28] = 8'h11; mem[29] = 8'h08;
    run_scan(8'h10, 1'b1, 0, 0, 8'h00);
    check("t3_count16",   obj_count, 1);
    check_entry("t3_entry16", 4'd0, {8'h08, 6'd7, 4'd15});
    run_scan(8'h10, 1'b0, 0, 0, 8'h00);
    check("t3_count8",    obj_count, 0);
    check_entry("t3_entry8", 4'd0, 18'd0);

    // Y = 16 hits line 0; last entry exercises the drain cycle.
    set_all(8'h00);
    mem[156] = 8'h10; mem[157] = 8'h99;
    run_scan(8'h00, 1'b0, 0, 0, 8'h00);
    check("t4_count",     obj_count, 1);
    check_entry("t4_entry0", 4'd0, {8'h99, 6'd39, 4'd0});

    // DMA high over cycles 1..40 masks entries 0..19.
    set_all(8'h30);
    run_scan(8'h20, 1'b0, 40, 0, 8'h00);
    check("t5_count",     obj_count, 10);
    check("t5_overflow",  overflow,  1);
    for (int i = 0; i < 10; i++) exp_q.push_back({8'(8'h10 + 20 + i), 6'(20 + i), 4'd0});
    for (int i = 0; i < 10; i++) check_entry($sformatf("t5_entry%0d", i), 4'(i), exp_q.pop_front());

    // Restart at cycle 30 with ly = 0x40: only entry 5 matches the new line.
    set_all(8'h30);
    mem[20] = 8'h4A; mem[21] = 8'h77;
    run_scan(8'h20, 1'b0, 0, 30, 8'h40);
    check("t6_done_cyc",  done_cyc, 112);
    check("t6_done_cnt",  done_cnt, 1);
    check("t6_busy_cnt",  busy_cnt, 112);
    check("t6_rd_cnt",    rd_cnt,   110);
    check("t6_addr_seq",  addr_err, 0);
    check("t6_count",     obj_count, 1);
    check("t6_overflow",  overflow,  0);
    check_entry("t6_entry0", 4'd0, {8'h77, 6'd5, 4'd6});

    // Asynchronous reset mid-scan, then silence until a new start.
    set_all(8'h30);
    @(negedge clk);
    start = 1'b1; ly = 8'h20; obj_size = 1'b0;
    for (int c = 1; c < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("t7_pre_count", obj_count, 10);
    rst_n = 1'b0;
    #1;
    check("t7_busy",      busy,      0);
    check("t7_oam_rd",    oam_rd,    0);
    check("t7_count",     obj_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("t7_no_done",   done_cnt, 0);
    check("t7_no_busy",   busy_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
